median_window_seq: RTL and testbench

MEDIAN_WINDOW_SEQ -- requirements
Module: median_window_seq

---
 rtl/median_window_seq_if.sv | 27 ++
 rtl/median_window_seq.sv | 182 ++++++++++++++++++
 tb/tb_median_window_seq.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/median_window_seq_if.sv
// rtl/median_window_seq_if.sv - pixel in, median out and median-engine signals
// The median engine is the master on its own M_DO/M_DSO pair; the sequencer is the slave here.
interface median_window_seq_if #(
  parameter int W = 8
) ();
  logic         IN_VALID;
  logic [W-1:0] IN_DATA;
  logic         IN_READY;
  logic         OUT_VALID;
  logic [W-1:0] OUT_DATA;
  logic         OUT_READY;
  logic [W-1:0] M_DI;
  logic         M_DSI;
  logic         M_nRST;
  logic [W-1:0] M_DO;
  logic         M_DSO;

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY, M_DO, M_DSO,
    output IN_READY, OUT_VALID, OUT_DATA, M_DI, M_DSI, M_nRST
  );

  modport master (
    output IN_VALID, IN_DATA, OUT_READY, M_DO, M_DSO,
    input  IN_READY, OUT_VALID, OUT_DATA, M_DI, M_DSI, M_nRST
  );
endinterface

// File: rtl/median_window_seq.sv
// rtl/median_window_seq.sv - sequences a 3x3 window into an external median engine
// Collects nine pixels, streams them to the engine, waits for the result or times out and resets it.
module median_window_seq #(
  parameter int W       = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                ERR_CLR,
  output logic                BUSY,
  output logic                ERR,
  median_window_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FEED,
    S_WAIT,
    S_HOLD,
    S_RECOVER
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [3:0]   f_q, f_d;
  logic [3:0]   f_next;
  logic [7:0]   timer_q, timer_d;
  logic         rec_q, rec_d;
  logic         post_rst_q, post_rst_d;
  logic [W-1:0] pix_q [0:8];
  logic [W-1:0] pix_d [0:8];
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         m_dsi_q, m_dsi_d;
  logic [W-1:0] m_di_q, m_di_d;
  logic         m_nrst_q, m_nrst_d;
  logic         err_q, err_d;
  logic         busy_q, busy_d;
  logic         beat;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    f_d         = f_q;
    f_next      = f_q + 4'd1;
    timer_d     = timer_q;
    rec_d       = rec_q;
    post_rst_d  = 1'b0;
    pix_d       = pix_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    m_dsi_d     = m_dsi_q;
    m_di_d      = m_di_q;
    // Engine reset is held one extra cycle after RST falls.
    m_nrst_d    = ~post_rst_q;
    err_d       = ERR_CLR ? 1'b0 : err_q;
    beat        = bus.IN_VALID & in_ready_q & (state_q == S_LOAD);

    case (state_q)
      S_LOAD: begin
        in_ready_d = 1'b1;
        if (beat) begin
          pix_d[cnt_q] = bus.IN_DATA;
          if (cnt_q == 4'd8) begin
            cnt_d      = 4'd0;
            f_d        = 4'd0;
            state_d    = S_FEED;
            in_ready_d = 1'b0;
            m_dsi_d    = 1'b1;
            m_di_d     = pix_q[0];
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_FEED: begin
        if (f_q == 4'd8) begin
          f_d     = 4'd0;
          timer_d = 8'd0;
          m_dsi_d = 1'b0;
          m_di_d  = '0;
          state_d = S_WAIT;
        end else begin
          f_d    = f_next;
          m_di_d = pix_q[f_next];
        end
      end
      S_WAIT: begin
        // A done strobe beats a simultaneous timeout.
        if (bus.M_DSO) begin
          out_data_d  = bus.M_DO;
          out_valid_d = 1'b1;
          timer_d     = 8'd0;
          state_d     = S_HOLD;
        end else if (timer_q == TO_LAST) begin
          err_d    = 1'b1;
          timer_d  = 8'd0;
          rec_d    = 1'b0;
          m_nrst_d = 1'b0;
          state_d  = S_RECOVER;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (bus.OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_LOAD;
        end
      end
      S_RECOVER: begin
        cnt_d    = 4'd0;
        m_nrst_d = 1'b0;
        if (rec_q) begin
          rec_d      = 1'b0;
          m_nrst_d   = 1'b1;
          in_ready_d = 1'b1;
          state_d    = S_LOAD;
        end else begin
          rec_d = 1'b1;
        end
      end
      default: state_d = S_LOAD;
    endcase

    busy_d = ~((state_d == S_LOAD) && (cnt_d == 4'd0));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_LOAD;
      cnt_q       <= 4'd0;
      f_q         <= 4'd0;
      timer_q     <= 8'd0;
      rec_q       <= 1'b0;
      post_rst_q  <= 1'b1;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      m_dsi_q     <= 1'b0;
      m_di_q      <= '0;
      m_nrst_q    <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      f_q         <= f_d;
      timer_q     <= timer_d;
      rec_q       <= rec_d;
      post_rst_q  <= post_rst_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      m_dsi_q     <= m_dsi_d;
      m_di_q      <= m_di_d;
      m_nrst_q    <= m_nrst_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  // Window storage is pure datapath; cnt alone decides what is valid.
  always_ff @(posedge CLK) begin
    pix_q <= pix_d;
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.M_DSI     = m_dsi_q;
  assign bus.M_DI      = m_di_q;
  assign bus.M_nRST    = m_nrst_q;
  assign BUSY          = busy_q;
  assign ERR           = err_q;

endmodule

// File: tb/tb_median_window_seq.sv
// tb/tb_median_window_seq.sv - scoreboard bench for median_window_seq
// Directed windows with hand-computed medians; a behavioural engine answers the strobes.
module tb_median_window_seq;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ERR_CLR = 1'b0;
  logic BUSY;
  logic ERR;

  median_window_seq_if #(.W(W)) bus ();

  median_window_seq #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .ERR_CLR (ERR_CLR),
    .BUSY    (BUSY),
    .ERR     (ERR),
    .bus     (bus.slave)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] di_q [$];
  logic [W-1:0] win [9];
  int eng_lat = 4;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Behavioural engine: median of nine strobed pixels, eng_lat cycles later; 0 = never answers.
  logic [W-1:0] eng_px [9];
  int eng_n = 0;
  int eng_cd = 0;
  logic [W-1:0] eng_med;

  always @(negedge CLK) begin
    logic [W-1:0] s [9];
    logic [W-1:0] t;
    bus.M_DSO = 1'b0;
    if (!bus.M_nRST) begin
      eng_n  = 0;
      eng_cd = 0;
    end else begin
      if (eng_cd > 0) begin
        eng_cd--;
        if (eng_cd == 0) begin
          bus.M_DSO = 1'b1;
          bus.M_DO  = eng_med;
        end
      end
      if (bus.M_DSI) begin
        eng_px[eng_n] = bus.M_DI;
        eng_n++;
        if (eng_n == 9) begin
          s = eng_px;
          for (int i = 1; i < 9; i++)
            for (int j = i; j > 0 && s[j-1] > s[j]; j--) begin
              t = s[j]; s[j] = s[j-1]; s[j-1] = t;
            end
          eng_med = s[4];
          eng_n   = 0;
          eng_cd  = eng_lat;
        end
      end
    end
  end

  int run = 0;
  always begin
    @(negedge CLK);
    #1;
    if (bus.M_DSI) begin
      run++;
      if (di_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL m_di: got strobe with %0d expected none", bus.M_DI);
      end else begin
        check("m_di", int'(bus.M_DI), int'(di_q.pop_front()));
      end
    end else begin
      if (run != 0 && bus.M_nRST) check("dsi_run", run, 9);
      run = 0;
    end
    if (bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL median: got unexpected result %0d expected none", bus.OUT_DATA);
      end else begin
        check("median", int'(bus.OUT_DATA), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic set_win(input int a0, input int a1, input int a2, input int a3, input int a4,
                         input int a5, input int a6, input int a7, input int a8);
    win[0] = 8'(a0); win[1] = 8'(a1); win[2] = 8'(a2);
    win[3] = 8'(a3); win[4] = 8'(a4); win[5] = 8'(a5);
    win[6] = 8'(a6); win[7] = 8'(a7); win[8] = 8'(a8);
  endtask

  task automatic send_window(input bit gaps, input int exp_med);
    int n;
    for (int i = 0; i < 9; i++) di_q.push_back(win[i]);
    if (exp_med >= 0) exp_q.push_back(8'(exp_med));
    for (int i = 0; i < 9; i++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = win[i];
      n = 0;
      while (!bus.IN_READY && n < 300) begin
        @(negedge CLK);
        n++;
      end
      if (n >= 300) begin
        checks++; errors++;
        $display("FAIL in_ready_wait: got no ready after %0d cycles expected ready", n);
        bus.IN_VALID = 1'b0;
        return;
      end
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      if (gaps && i < 8) @(negedge CLK);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_wait0();
    int n = 0;
    while (!bus.M_DSI && n < 300) begin @(negedge CLK); n++; end
    while (bus.M_DSI && n < 300) begin @(negedge CLK); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL feed_wait: got no feed after %0d cycles expected feed", n);
    end
  endtask

  initial begin
    int n;
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = '0;
    bus.OUT_READY = 1'b1;
    bus.M_DSO     = 1'b0;
    bus.M_DO      = '0;

    repeat (3) @(negedge CLK);
    check("rst_in_ready", int'(bus.IN_READY), 0);
    check("rst_out_valid", int'(bus.OUT_VALID), 0);
    check("rst_out_data", int'(bus.OUT_DATA), 0);
    check("rst_m_dsi", int'(bus.M_DSI), 0);
    check("rst_m_di", int'(bus.M_DI), 0);
    check("rst_m_nrst", int'(bus.M_nRST), 0);
    check("rst_err", int'(ERR), 0);
    check("rst_busy", int'(BUSY), 0);
    RST = 1'b0;
    @(negedge CLK);
    check("post_rst_m_nrst", int'(bus.M_nRST), 0);
    check("post_rst_in_ready", int'(bus.IN_READY), 1);
    @(negedge CLK);
    check("post_rst2_m_nrst", int'(bus.M_nRST), 1);

    // Basic window, median 50
    eng_lat = 4;
    set_win(10, 90, 30, 70, 50, 20, 80, 40, 60);
    send_window(1'b0, 50);
    drain();
    check("w1_busy", int'(BUSY), 0);
    check("w1_in_ready", int'(bus.IN_READY), 1);

    // Gapped load, median 42; feed must start right after the ninth beat
    set_win(5, 200, 17, 99, 3, 150, 42, 77, 8);
    send_window(1'b1, 42);
    check("w2_feed_start", int'(bus.M_DSI), 1);
    check("w2_feed_first", int'(bus.M_DI), 5);
    check("w2_busy", int'(BUSY), 1);
    check("w2_in_ready", int'(bus.IN_READY), 0);
    drain();

    // Downstream stall in HOLD, median 128
    bus.OUT_READY = 1'b0;
    set_win(255, 0, 128, 128, 1, 254, 127, 129, 128);
    send_window(1'b0, 128);
    n = 0;
    while (!bus.OUT_VALID && n < 300) begin @(negedge CLK); n++; end
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", int'(bus.OUT_VALID), 1);
      check("hold_data", int'(bus.OUT_DATA), 128);
      check("hold_in_ready", int'(bus.IN_READY), 0);
      @(negedge CLK);
    end
    bus.OUT_READY = 1'b1;
    @(negedge CLK);
    check("hold_release_valid", int'(bus.OUT_VALID), 0);
    check("hold_release_in_ready", int'(bus.IN_READY), 1);
    drain();

    // Engine never answers: timeout after 64 WAIT cycles
    eng_lat = 0;
    set_win(1, 2, 3, 4, 5, 6, 7, 8, 9);
    send_window(1'b0, -1);
    wait_wait0();
    repeat (TIMEOUT - 1) @(negedge CLK);
    check("to_err_before", int'(ERR), 0);
    @(negedge CLK);
    check("to_err_set", int'(ERR), 1);
    check("to_nrst_1", int'(bus.M_nRST), 0);
    check("to_in_ready_rec", int'(bus.IN_READY), 0);
    @(negedge CLK);
    check("to_nrst_2", int'(bus.M_nRST), 0);
    @(negedge CLK);
    check("to_nrst_release", int'(bus.M_nRST), 1);
    check("to_in_ready", int'(bus.IN_READY), 1);
    check("to_busy", int'(BUSY), 0);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    check("err_clr", int'(ERR), 0);

    // Reset at f=4 of FEED, then a fresh window with median 55
    eng_lat = 4;
    set_win(9, 8, 7, 6, 5, 4, 3, 2, 1);
    send_window(1'b0, -1);
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("midrst_m_dsi", int'(bus.M_DSI), 0);
    check("midrst_m_nrst", int'(bus.M_nRST), 0);
    check("midrst_out_valid", int'(bus.OUT_VALID), 0);
    check("midrst_in_ready", int'(bus.IN_READY), 0);
    check("midrst_busy", int'(BUSY), 0);
    RST = 1'b0;
    di_q.delete();
    @(negedge CLK);
    check("midrst_post_nrst", int'(bus.M_nRST), 0);
    @(negedge CLK);
    check("midrst_post2_nrst", int'(bus.M_nRST), 1);
    set_win(11, 22, 33, 44, 55, 66, 77, 88, 99);
    send_window(1'b0, 55);
    drain();

    // Done strobe on the last timer value wins over the timeout, median 7
    eng_lat = TIMEOUT;
    set_win(7, 7, 7, 3, 3, 3, 9, 9, 9);
    send_window(1'b0, 7);
    drain();
    check("late_dso_err", int'(ERR), 0);

    // ERR_CLR in the timeout cycle: set wins
    eng_lat = 0;
    set_win(1, 2, 3, 4, 5, 6, 7, 8, 9);
    send_window(1'b0, -1);
    wait_wait0();
    repeat (TIMEOUT - 1) @(negedge CLK);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    check("clr_vs_set_err", int'(ERR), 1);
    check("clr_vs_set_nrst", int'(bus.M_nRST), 0);
    repeat (2) @(negedge CLK);
    check("clr_vs_set_in_ready", int'(bus.IN_READY), 1);
    check("clr_vs_set_err_sticky", int'(ERR), 1);
    repeat (3) @(negedge CLK);
    check("queues_empty", di_q.size() + exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
